ex_muldiv_ctrl: RTL and testbench
=================================

Name: ex_muldiv_ctrl

Overview:
- Iterative sequencer for RV32M multiply/divide, attached alongside the EX-stage ALU.
- Accepts an M-type operation from EX, runs a 32-iteration shift-add multiply or restoring divide, and stalls the pipeline until the result is ready.
- Owns the FSM, iteration counter and sign fix-up. Returns a 32-bit result that EX muxes onto its ALU result path.

Parameters:
- WIDTH, 32: operand/result width; only 32 is supported.
- EARLY_OUT, 1: when 1, divide-by-zero and signed-overflow cases skip iteration.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-low (state resets on a clk edge while rst==0)
- req_valid  in  1  EX holds an M-type instruction
- req_op  in  3  muldiv::muldiv_op_t (funct3 encoding): MUL=000 MULH=001 MULHSU=010 MULHU=011 DIV=100 DIVU=101 REM=110 REMU=111
- req_a  in  32  rs1 value (forwarded)
- req_b  in  32  rs2 value (forwarded)
- flush  in  1  squash the in-flight op (taken branch/jump)
- busy  out  1  stall request to the pipeline, combinational
- resp_valid  out  1  one-cycle result strobe
- resp_data  out  32  result; holds its last value until the next DONE

Behaviour:
- Reset values: state=IDLE, counter=0, resp_valid=0, resp_data=0, busy=0 (busy has no rst term).
- States: IDLE, CALC, FIXUP, DONE.
- IDLE:
  - If req_valid && !flush, latch op, operand signs and magnitudes, set counter=31.
  - Next state: DONE if early-out applies, otherwise CALC.
- CALC:
  - One iteration per cycle; counter decrements.
  - Exit to FIXUP when counter==0 and that iteration completes (32 iterations total).
- FIXUP:
  - Apply sign correction.
  - Select product low word (MUL) or high word (MULH*), or quotient/remainder.
  - Go to DONE.
- DONE: resp_valid=1 and resp_data registered for this cycle; go to IDLE.
- busy = (IDLE && req_valid && !flush) || CALC || FIXUP. busy=0 in DONE so the pipeline advances.
- Latency:
  - Accept cycle = 0; resp_valid asserted in cycle 34 (1 + 32 + 1 + DONE).
  - Early-out: resp_valid in cycle 1.
- Back-to-back: req_valid in the cycle after DONE is a new op and is accepted from IDLE. No bubble is inserted by this block.
- Multiply:
  - Unsigned 32x32 shift-add on magnitudes into a 64-bit accumulator.
  - MUL/MULH treat both operands as signed; MULHSU treats a as signed and b as unsigned; MULHU treats both as unsigned.
  - Negate the 64-bit product when the effective signs differ.
- Divide:
  - Restoring division on magnitudes; 33-bit partial remainder, 32-bit quotient.
  - DIV/REM are signed: quotient sign = sa^sb; remainder sign = sa.
  - DIVU/REMU are unsigned.
- Early-out (EARLY_OUT=1):
  - b==0: DIV/DIVU result 0xFFFFFFFF; REM/REMU result a.
  - Signed a==0x80000000, b==0xFFFFFFFF: DIV result 0x80000000; REM result 0.
- Early-out with EARLY_OUT=0: the iterative path must produce the same RISC-V-defined results.
- Flush:
  - Any state goes to IDLE on the next edge; resp_valid is never asserted for the squashed op.
  - flush && req_valid in IDLE: request not accepted.
  - flush in the DONE cycle: the resp_valid strobe still appears; EX discards it.
- rst==0 mid-operation: the op is abandoned; reset values apply after the edge.
- req_a, req_b and req_op are sampled only at accept; later changes are ignored.

Decomposition:
- Add package muldiv to rv32i_types, alongside pcmux/alumux, containing:
  - muldiv_op_t enum (funct3 values)
  - muldiv_state_t enum
  - a muldiv_sel bit in rv32i_control_word for the EX result mux
- Natural sub-module: muldiv_dp. It holds accumulator/remainder/quotient registers, the 33-bit adder-subtractor and the negators, driven by load/step/fixup strobes from the FSM in ex_muldiv_ctrl.

Test Plan:
- MUL a=7 b=0xFFFFFFFD -> busy high cycles 0..33, resp_valid only at cycle 34, resp_data=0xFFFFFFEB.
- High-word multiplies:
  - MULH 0x80000000*0x80000000 -> 0x40000000
  - MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF
- Divide/remainder:
  - DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF
  - DIVU 100/7 -> 14; REMU 100/7 -> 2
- Early-out, each with resp_valid at cycle 1:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0
- Flush in CALC cycle 10 -> IDLE next cycle, busy=0, no resp_valid. A new MULHU request the following cycle returns the correct result at +34.
- rst=0 at cycle 5 of a DIV -> resp_valid=0, resp_data=0, busy follows req_valid only. A back-to-back pair MUL 3*4 then DIVU 9/2 (req held after DONE) -> results 12 then 4, second accepted the cycle after the first DONE.

Source files
------------

// File: rtl/ex_muldiv_ctrl_pkg.sv
// Shared types for the RV32M multiply/divide sequencer: funct3 op encoding,
// FSM states, operand-sign helpers and the EX result-mux control bit.
package ex_muldiv_ctrl_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_FIXUP = 2'd2,
        S_DONE  = 2'd3
    } muldiv_state_t;

    typedef struct packed {
        logic muldiv_sel;
    } rv32i_control_word_t;

    function automatic logic isSignedA(input muldiv_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic isSignedB(input muldiv_op_t op);
        return op inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/ex_muldiv_ctrl_dp.sv
// Datapath for the iterative multiplier/divider: shared accumulator, divisor
// register, the adder-subtractor and the result negators.
module ex_muldiv_ctrl_dp #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_isDiv,
    input  logic             i_negProd,
    input  logic             i_negQuo,
    input  logic             i_negRem,
    input  logic             i_selUpper,
    input  logic [WIDTH-1:0] i_magA,
    input  logic [WIDTH-1:0] i_magB,
    output logic [WIDTH-1:0] o_result
);

    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH:0]     w_addA;
    logic [WIDTH:0]     w_addB;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;

    // Multiply keeps {high partial, remaining multiplier}; divide keeps {remainder, quotient}.
    assign w_addA = i_isDiv ? r_acc[2*WIDTH-1:WIDTH-1] : {1'b0, r_acc[2*WIDTH-1:WIDTH]};
    assign w_addB = i_isDiv ? ~{1'b0, r_divisor}
                            : (r_acc[0] ? {1'b0, r_divisor} : '0);
    assign w_sum  = w_addA + w_addB + (WIDTH+1)'(i_isDiv);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_acc     <= '0;
            r_divisor <= '0;
        end else if (i_load) begin
            r_acc     <= {{WIDTH{1'b0}}, i_magA};
            r_divisor <= i_magB;
        end else if (i_step) begin
            if (i_isDiv) begin
                if (!w_sum[WIDTH])
                    r_acc <= {w_sum[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
                else
                    r_acc <= {r_acc[2*WIDTH-2:WIDTH-1], r_acc[WIDTH-2:0], 1'b0};
            end else begin
                r_acc <= {w_sum, r_acc[WIDTH-1:1]};
            end
        end
    end

    assign w_prod = i_negProd ? -r_acc : r_acc;
    assign w_quo  = i_negQuo ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = i_negRem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        o_result = '0;
        if (i_isDiv)
            o_result = i_selUpper ? w_rem : w_quo;
        else
            o_result = i_selUpper ? w_prod[2*WIDTH-1:WIDTH] : w_prod[WIDTH-1:0];
    end

endmodule

// File: rtl/ex_muldiv_ctrl.sv
// RV32M sequencer beside the EX ALU: accepts an M-type op, iterates 32 steps,
// applies sign fix-up and returns a one-cycle result strobe while stalling EX.
module ex_muldiv_ctrl
    import ex_muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    input  muldiv_op_t       req_op,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             flush,
    output logic             busy,
    output logic             resp_valid,
    output logic [WIDTH-1:0] resp_data
);

    localparam int CW = $clog2(WIDTH);

    muldiv_state_t    r_state;
    muldiv_state_t    w_nextState;
    logic [CW-1:0]    r_count;
    muldiv_op_t       r_op;
    logic             r_signA;
    logic             r_signB;
    logic             r_bZero;
    logic [WIDTH-1:0] r_respData;

    logic             w_accept;
    logic             w_step;
    logic             w_signA;
    logic             w_signB;
    logic [WIDTH-1:0] w_magA;
    logic [WIDTH-1:0] w_magB;
    logic             w_bZero;
    logic             w_overflow;
    logic             w_early;
    logic [WIDTH-1:0] w_earlyData;
    logic [WIDTH-1:0] w_dpResult;

    assign w_accept   = (r_state == S_IDLE) && req_valid && !flush;
    assign w_step     = (r_state == S_CALC) && !flush;
    assign w_signA    = isSignedA(req_op) & req_a[WIDTH-1];
    assign w_signB    = isSignedB(req_op) & req_b[WIDTH-1];
    assign w_magA     = w_signA ? -req_a : req_a;
    assign w_magB     = w_signB ? -req_b : req_b;
    assign w_bZero    = (req_b == '0);
    assign w_overflow = (req_op inside {OP_DIV, OP_REM})
                        && (req_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&req_b);
    assign w_early    = EARLY_OUT && req_op[2] && (w_bZero || w_overflow);

    // req_op[1] distinguishes REM/REMU from DIV/DIVU.
    always_comb begin
        w_earlyData = '0;
        if (w_bZero)
            w_earlyData = req_op[1] ? req_a : '1;
        else
            w_earlyData = req_op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= S_IDLE;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        busy        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    busy        = 1'b1;
                    w_nextState = w_early ? S_DONE : S_CALC;
                end
            end
            S_CALC: begin
                busy = 1'b1;
                if (flush)
                    w_nextState = S_IDLE;
                else if (r_count == '0)
                    w_nextState = S_FIXUP;
            end
            S_FIXUP: begin
                busy        = 1'b1;
                w_nextState = flush ? S_IDLE : S_DONE;
            end
            S_DONE: w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_count    <= '0;
            r_op       <= OP_MUL;
            r_signA    <= 1'b0;
            r_signB    <= 1'b0;
            r_bZero    <= 1'b0;
            r_respData <= '0;
        end else begin
            if (w_accept) begin
                r_count <= '1;
                r_op    <= req_op;
                r_signA <= w_signA;
                r_signB <= w_signB;
                r_bZero <= w_bZero;
                if (w_early)
                    r_respData <= w_earlyData;
            end else if (w_step) begin
                r_count <= r_count - CW'(1);
            end
            if ((r_state == S_FIXUP) && !flush)
                r_respData <= w_dpResult;
        end
    end

    // A zero divisor leaves an all-ones magnitude quotient that must not be negated.
    ex_muldiv_ctrl_dp #(.WIDTH(WIDTH)) u_dp (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_accept),
        .i_step     (w_step),
        .i_isDiv    (r_op[2]),
        .i_negProd  (r_signA ^ r_signB),
        .i_negQuo   ((r_signA ^ r_signB) && !r_bZero),
        .i_negRem   (r_signA),
        .i_selUpper (r_op[2] ? r_op[1] : (r_op[1] | r_op[0])),
        .i_magA     (w_magA),
        .i_magB     (w_magB),
        .o_result   (w_dpResult)
    );

    assign resp_valid = (r_state == S_DONE);
    assign resp_data  = r_respData;

endmodule

// File: tb/tb_ex_muldiv_ctrl.sv
// Directed self-checking bench for ex_muldiv_ctrl with hand-computed results.
module tb_ex_muldiv_ctrl;
    import ex_muldiv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    muldiv_op_t  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        flush;
    logic        busy;
    logic        resp_valid;
    logic [31:0] resp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ex_muldiv_ctrl #(.WIDTH(32), .EARLY_OUT(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .flush      (flush),
        .busy       (busy),
        .resp_valid (resp_valid),
        .resp_data  (resp_data)
    );

    // Issue one op at posedge+1, scramble inputs after accept, then watch for the strobe.
    task automatic applyStimulus(input muldiv_op_t op, input logic [31:0] a, input logic [31:0] b,
                                 output int lat, output logic [31:0] data, output int busyCnt,
                                 output logic busyAtDone, output logic strobeAfter);
        lat = -1; data = '0; busyCnt = 0; busyAtDone = 1'b1; strobeAfter = 1'b0;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        #1;
        if (busy) busyCnt++;
        @(posedge clk); #1;
        req_valid = 1'b0; req_op = OP_MULHU; req_a = 32'hA5A5_5A5A; req_b = 32'h0F0F_F0F0;
        for (int c = 1; c <= 40; c++) begin
            #1;
            if (resp_valid) begin
                lat = c; data = resp_data; busyAtDone = busy;
                break;
            end
            if (busy) busyCnt++;
            @(posedge clk); #1;
        end
        @(posedge clk); #1; #1;
        strobeAfter = resp_valid;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        checks++; if (resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_resp_valid: got %b expected 0", resp_valid); end
        checks++; if (resp_data !== 32'h0) begin errors++; $display("[TB] FAIL reset_resp_data: got %h expected 00000000", resp_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b1;
        @(posedge clk); #1; #1;
        checks++; if (busy !== 1'b0 || resp_valid !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset: got busy=%b resp_valid=%b expected 0/0", busy, resp_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        int lat, busyCnt; logic [31:0] data; logic busyAtDone, strobeAfter;
        applyStimulus(OP_MUL, 32'd7, 32'hFFFF_FFFD, lat, data, busyCnt, busyAtDone, strobeAfter);
        checks++; if (lat !== 34) begin errors++; $display("[TB] FAIL mul_latency: got %0d expected 34", lat); end
        checks++; if (data !== 32'hFFFF_FFEB) begin errors++; $display("[TB] FAIL mul_data: got %h expected ffffffeb", data); end
        checks++; if (busyCnt !== 34) begin errors++; $display("[TB] FAIL mul_busy_cycles: got %0d expected 34", busyCnt); end
        checks++; if (busyAtDone !== 1'b0) begin errors++; $display("[TB] FAIL mul_busy_at_done: got %b expected 0", busyAtDone); end
        checks++; if (strobeAfter !== 1'b0) begin errors++; $display("[TB] FAIL mul_strobe_width: got %b expected 0", strobeAfter); end
    endtask

    task automatic test_mul_high();
        int lat, busyCnt; logic [31:0] data; logic busyAtDone, strobeAfter;
        applyStimulus(OP_MULH, 32'h8000_0000, 32'h8000_0000, lat, data, busyCnt, busyAtDone, strobeAfter);
        checks++; if (lat !== 34 || data !== 32'h4000_0000) begin errors++; $display("[TB] FAIL mulh: got lat=%0d data=%h expected 34/40000000", lat, data); end
        applyStimulus(OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, data, busyCnt, busyAtDone, strobeAfter);
        checks++; if (lat !== 34 || data !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL mulhu: got lat=%0d data=%h expected 34/fffffffe", lat, data); end
        applyStimulus(OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, data, busyCnt, busyAtDone, strobeAfter);
        checks++; if (lat !== 34 || data !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL mulhsu: got lat=%0d data=%h expected 34/ffffffff", lat, data); end
    endtask

    task automatic test_divide();
        int lat, busyCnt; logic [31:0] data; logic busyAtDone, strobeAfter;
        applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2, lat, data, busyCnt, busyAtDone, strobeAfter);
        checks++; if (lat !== 34 || data !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL div_signed: got lat=%0d data=%h expected 34/fffffffd", lat, data); end
        applyStimulus(OP_REM, 32'hFFFF_FFF9, 32'd2, lat, data, busyCnt, busyAtDone, strobeAfter);
        checks++; if (lat !== 34 || data !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL rem_signed: got lat=%0d data=%h expected 34/ffffffff", lat, data); end
        applyStimulus(OP_DIVU, 32'd100, 32'd7, lat, data, busyCnt, busyAtDone, strobeAfter);
        checks++; if (lat !== 34 || data !== 32'd14) begin errors++; $display("[TB] FAIL divu: got lat=%0d data=%h expected 34/0000000e", lat, data); end
        applyStimulus(OP_REMU, 32'd100, 32'd7, lat, data, busyCnt, busyAtDone, strobeAfter);
        checks++; if (lat !== 34 || data !== 32'd2) begin errors++; $display("[TB] FAIL remu: got lat=%0d data=%h expected 34/00000002", lat, data); end
    endtask

    task automatic test_early_out();
        int lat, busyCnt; logic [31:0] data; logic busyAtDone, strobeAfter;
        applyStimulus(OP_DIV, 32'd5, 32'd0, lat, data, busyCnt, busyAtDone, strobeAfter);
        checks++; if (lat !== 1 || data !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL early_div_zero: got lat=%0d data=%h expected 1/ffffffff", lat, data); end
        checks++; if (busyCnt !== 1) begin errors++; $display("[TB] FAIL early_busy_cycles: got %0d expected 1", busyCnt); end
        applyStimulus(OP_REMU, 32'd5, 32'd0, lat, data, busyCnt, busyAtDone, strobeAfter);
        checks++; if (lat !== 1 || data !== 32'd5) begin errors++; $display("[TB] FAIL early_remu_zero: got lat=%0d data=%h expected 1/00000005", lat, data); end
        applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat, data, busyCnt, busyAtDone, strobeAfter);
        checks++; if (lat !== 1 || data !== 32'h8000_0000) begin errors++; $display("[TB] FAIL early_div_ovf: got lat=%0d data=%h expected 1/80000000", lat, data); end
        applyStimulus(OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, lat, data, busyCnt, busyAtDone, strobeAfter);
        checks++; if (lat !== 1 || data !== 32'h0) begin errors++; $display("[TB] FAIL early_rem_ovf: got lat=%0d data=%h expected 1/00000000", lat, data); end
    endtask

    task automatic test_flush();
        int lat, busyCnt, busyHigh, sawResp; logic [31:0] data; logic busyAtDone, strobeAfter;
        busyHigh = 0; sawResp = 0;
        req_valid = 1'b1; req_op = OP_MUL; req_a = 32'd7; req_b = 32'd3;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            #1;
            if (busy) busyHigh++;
            if (resp_valid) sawResp++;
            if (c == 10) flush = 1'b1;
            @(posedge clk); #1;
        end
        flush = 1'b0;
        #1;
        checks++; if (busyHigh !== 10) begin errors++; $display("[TB] FAIL flush_calc_busy: got %0d expected 10", busyHigh); end
        checks++; if (busy !== 1'b0 || resp_valid !== 1'b0 || sawResp !== 0) begin errors++; $display("[TB] FAIL flush_to_idle: got busy=%b resp_valid=%b strobes=%0d expected 0/0/0", busy, resp_valid, sawResp); end
        @(posedge clk); #1;
        applyStimulus(OP_MULHU, 32'h8000_0000, 32'd6, lat, data, busyCnt, busyAtDone, strobeAfter);
        checks++; if (lat !== 34 || data !== 32'd3) begin errors++; $display("[TB] FAIL after_flush_mulhu: got lat=%0d data=%h expected 34/00000003", lat, data); end
    endtask

    task automatic test_rst_mid_op();
        int sawResp;
        sawResp = 0;
        req_valid = 1'b1; req_op = OP_DIV; req_a = 32'd100; req_b = 32'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c < 5; c++) begin
            @(posedge clk); #1;
        end
        rst = 1'b0;
        @(posedge clk); #1; #1;
        checks++; if (resp_valid !== 1'b0 || resp_data !== 32'h0) begin errors++; $display("[TB] FAIL rst_mid_outputs: got resp_valid=%b resp_data=%h expected 0/00000000", resp_valid, resp_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy_low: got %b expected 0", busy); end
        req_valid = 1'b1; #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_busy_follows_req: got %b expected 1", busy); end
        req_valid = 1'b0; #1;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (resp_valid) sawResp++;
            @(posedge clk); #1;
        end
        checks++; if (sawResp !== 0) begin errors++; $display("[TB] FAIL rst_mid_no_strobe: got %0d strobes expected 0", sawResp); end
    endtask

    task automatic test_back_to_back();
        int firstLat, secondLat, secondStart;
        logic [31:0] data1, data2;
        logic busyAtSecond, switchNext;
        firstLat = -1; secondLat = -1; secondStart = -1; busyAtSecond = 1'b0; switchNext = 1'b0;
        data1 = '0; data2 = '0;
        req_valid = 1'b1; req_op = OP_MUL; req_a = 32'd3; req_b = 32'd4;
        for (int c = 0; c < 100; c++) begin
            #1;
            if (c == secondStart) busyAtSecond = busy;
            if (resp_valid) begin
                if (firstLat < 0) begin
                    firstLat = c; data1 = resp_data; switchNext = 1'b1;
                end else begin
                    secondLat = c; data2 = resp_data; req_valid = 1'b0;
                    break;
                end
            end
            @(posedge clk); #1;
            if (switchNext) begin
                req_op = OP_DIVU; req_a = 32'd9; req_b = 32'd2;
                secondStart = c + 1; switchNext = 1'b0;
            end
        end
        req_valid = 1'b0;
        checks++; if (firstLat !== 34 || data1 !== 32'd12) begin errors++; $display("[TB] FAIL b2b_first: got lat=%0d data=%h expected 34/0000000c", firstLat, data1); end
        checks++; if (busyAtSecond !== 1'b1) begin errors++; $display("[TB] FAIL b2b_accept_after_done: got busy=%b expected 1", busyAtSecond); end
        checks++; if (secondLat !== 69 || data2 !== 32'd4) begin errors++; $display("[TB] FAIL b2b_second: got cycle=%0d data=%h expected 69/00000004", secondLat, data2); end
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b0; req_valid = 1'b0; req_op = OP_MUL; req_a = '0; req_b = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1; #1;
        $display("[TB] starting directed tests");
        test_reset();
        test_mul();
        test_mul_high();
        test_divide();
        test_early_out();
        test_flush();
        test_rst_mid_op();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
